// File: rtl/tile_noc_pkg.sv
// Shared constants, size-field positions and drain FSM states for the tile
// cluster write path.
package tile_noc_pkg;

  localparam int LINE_WORDS  = 8;
  localparam int WORD_W      = 66;
  localparam int LINE_W      = LINE_WORDS * WORD_W;
  localparam int ADDR_W      = 37;
  localparam int MEM_ADDR_W  = ADDR_W + 3;
  localparam int DONE_ADDR_W = ADDR_W + 10;
  localparam int SZ_W        = 12;

  localparam int SZ_SHARED   = 11;
  localparam int SZ_EXCL     = 10;
  localparam int SZ_MSK_HI   = 9;
  localparam int SZ_MSK_LO   = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } drain_state_e;

  // Expected check bits {^upper half, ^lower half} of a 64-bit payload.
  function automatic logic [1:0] word_parity(input logic [63:0] w);
    return {^w[63:32], ^w[31:0]};
  endfunction

endpackage

// File: rtl/tile_ffs8.sv
// 8-bit find-first-set: lowest set bit of vec at or above start.
module tile_ffs8 (
  input  logic [7:0] vec,
  input  logic [2:0] start,
  output logic       found,
  output logic [2:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = 3'd0;
    // Scan downward so the lowest qualifying bit is the last one written.
    for (int i = 7; i >= 0; i--) begin
      if (vec[i] && (i >= int'(start))) begin
        found = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/tilexy_cl_drain.sv
// Drains line requests from the cluster FIFO into a skid buffer and writes
// them word by word to the tile memory port. Optional macro: TILE_DRAIN_ECC_EN.
module tilexy_cl_drain
  import tile_noc_pkg::*;
#(
  parameter int tile_X = 0,
  parameter int tile_Y = 0,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [LINE_W-1:0]      req_data,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [SZ_W-1:0]        req_size,
  output logic                   req_pop,
  output logic                   mem_wen,
  output logic [MEM_ADDR_W-1:0]  mem_addr,
  output logic [WORD_W-1:0]      mem_wdata,
  input  logic                   mem_ready,
  output logic                   done_valid,
  output logic [DONE_ADDR_W-1:0] done_addr,
  output logic                   done_excl,
  output logic                   err
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [4:0]  TILE_X5 = 5'(tile_X);
  localparam logic [4:0]  TILE_Y5 = 5'(tile_Y);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          full, empty;

  logic [LINE_W-1:0] buf_data [DEPTH];
  logic [ADDR_W-1:0] buf_addr [DEPTH];
  logic [7:0]        buf_mask [DEPTH];
  logic              buf_excl [DEPTH];

  drain_state_e      state_q, state_d;
  logic [LINE_W-1:0] line_data_q, line_data_d;
  logic [ADDR_W-1:0] line_addr_q, line_addr_d;
  logic [7:0]        line_mask_q, line_mask_d;
  logic              line_excl_q, line_excl_d;
  logic [2:0]        word_idx_q, word_idx_d;

  logic [WORD_W-1:0] line_word [LINE_WORDS];
  logic [WORD_W-1:0] cur_word;
  logic              word_bad;
  logic [7:0]        ffs_vec;
  logic [2:0]        ffs_start, ffs_idx;
  logic              ffs_found;

  logic unused_size;
  assign unused_size = ^{req_size[SZ_SHARED], req_size[SZ_MSK_HI:SZ_MSK_HI-1]};

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});

  // Gated by reset so nothing is taken from the FIFO while the buffer is held clear.
  assign req_pop = rst & req_valid & ~full;

  always_ff @(posedge clk) begin
    if (req_pop) begin
      buf_data[wr_idx] <= req_data;
      buf_addr[wr_idx] <= req_addr;
      buf_mask[wr_idx] <= req_size[SZ_MSK_LO +: 8];
      buf_excl[wr_idx] <= req_size[SZ_EXCL];
    end
  end

  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
    assign line_word[gi] = line_data_q[gi*WORD_W +: WORD_W];
  end
  assign cur_word = line_word[word_idx_q];

`ifdef TILE_DRAIN_ECC_EN
  assign word_bad = (cur_word[65:64] != word_parity(cur_word[63:0]));
`else
  assign word_bad = 1'b0;
`endif

  // One search unit: IDLE looks for the first word of the head entry,
  // WRITE looks for the next word above the current one.
  assign ffs_vec   = (state_q == IDLE) ? buf_mask[rd_idx] : line_mask_q;
  assign ffs_start = (state_q == IDLE) ? 3'd0 : word_idx_q + 3'd1;

  tile_ffs8 u_ffs (
    .vec   (ffs_vec),
    .start (ffs_start),
    .found (ffs_found),
    .idx   (ffs_idx)
  );

  always_comb begin
    state_d     = state_q;
    line_data_d = line_data_q;
    line_addr_d = line_addr_q;
    line_mask_d = line_mask_q;
    line_excl_d = line_excl_q;
    word_idx_d  = word_idx_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = req_pop ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    mem_wen     = 1'b0;
    err         = 1'b0;
    done_valid  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          line_data_d = buf_data[rd_idx];
          line_addr_d = buf_addr[rd_idx];
          line_mask_d = buf_mask[rd_idx];
          line_excl_d = buf_excl[rd_idx];
          if (ffs_found) begin
            word_idx_d = ffs_idx;
            state_d    = WRITE;
          end else begin
            state_d    = DONE;
          end
        end
      end
      WRITE: begin
        mem_wen = ~word_bad;
        err     = word_bad;
        // A corrupt word is consumed without waiting for the memory.
        if ((mem_wen && mem_ready) || word_bad) begin
          if (ffs_found && (word_idx_q != 3'd7)) begin
            word_idx_d = ffs_idx;
          end else begin
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        done_valid = 1'b1;
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = (state_q == WRITE) ? {line_addr_q, word_idx_q} : '0;
  assign mem_wdata = (state_q == WRITE) ? cur_word : '0;
  assign done_addr = done_valid ? {TILE_Y5, TILE_X5, line_addr_q} : '0;
  assign done_excl = done_valid & line_excl_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      line_data_q <= '0;
      line_addr_q <= '0;
      line_mask_q <= '0;
      line_excl_q <= 1'b0;
      word_idx_q  <= 3'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      line_data_q <= line_data_d;
      line_addr_q <= line_addr_d;
      line_mask_q <= line_mask_d;
      line_excl_q <= line_excl_d;
      word_idx_q  <= word_idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

endmodule

// File: tb/tb_tilexy_cl_drain.sv
// Randomised and directed bench for tilexy_cl_drain against a line/word scoreboard.
module tb_tilexy_cl_drain;
  import tile_noc_pkg::*;

  localparam int TX  = 3;
  localparam int TY  = 5;
  localparam int DEP = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   req_valid = 1'b0;
  logic [LINE_W-1:0]      req_data = '0;
  logic [ADDR_W-1:0]      req_addr = '0;
  logic [SZ_W-1:0]        req_size = '0;
  logic                   req_pop;
  logic                   mem_wen;
  logic [MEM_ADDR_W-1:0]  mem_addr;
  logic [WORD_W-1:0]      mem_wdata;
  logic                   mem_ready = 1'b1;
  logic                   done_valid;
  logic [DONE_ADDR_W-1:0] done_addr;
  logic                   done_excl;
  logic                   err;

  tilexy_cl_drain #(.tile_X(TX), .tile_Y(TY), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_addr(req_addr), .req_size(req_size), .req_pop(req_pop),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .done_valid(done_valid), .done_addr(done_addr),
    .done_excl(done_excl), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  // Expected word events {bad, mem_addr, word} and completions {done_addr, excl}.
  logic [106:0] exp_wr[$];
  logic [47:0]  exp_done[$];
  logic [106:0] mon_e;
  logic [47:0]  mon_d;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [65:0] mkword(input bit corrupt);
    logic [63:0] w;
    w = {$urandom, $urandom};
    return {(^w[63:32]) ^ corrupt, ^w[31:0], w};
  endfunction

  task automatic new_req(input logic [7:0] mask, input bit corrupt);
    logic [63:0] r;
    r = {$urandom, $urandom};
    req_addr = r[36:0];
    for (int i = 0; i < 8; i++)
      req_data[66*i +: 66] = mkword(corrupt && ($urandom_range(0, 7) == 0));
    req_size = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), mask};
  endtask

  task automatic model_push(input logic [527:0] d, input logic [36:0] a, input logic [11:0] s);
    logic [65:0] w;
    bit bad;
    for (int i = 0; i < 8; i++) begin
      if (s[i]) begin
        w = d[66*i +: 66];
        bad = 1'b0;
`ifdef TILE_DRAIN_ECC_EN
        bad = (w[65:64] != {^w[63:32], ^w[31:0]});
`endif
        exp_wr.push_back({bad, a, 3'(i), w});
      end
    end
    exp_done.push_back({5'(TY), 5'(TX), a, s[10]});
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      exp_wr.delete();
      exp_done.delete();
    end else begin
      if ((mem_wen && mem_ready) || err) begin
        if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          mon_e = exp_wr.pop_front();
          check("wr_kind", err, mon_e[106]);
          if (!err) begin
            check("wr_addr", mem_addr, mon_e[105:66]);
            check("wr_data", mem_wdata, mon_e[65:0]);
          end
        end
      end
      if (done_valid) begin
        done_cnt++;
        if (exp_done.size() == 0) check("done_unexpected", 1, 0);
        else begin
          mon_d = exp_done.pop_front();
          check("done_addr", done_addr, mon_d[47:1]);
          check("done_excl", done_excl, mon_d[0]);
          $display("DONE #%0d cyc=%0d addr=%h excl=%0d", done_cnt, cyc, done_addr, done_excl);
        end
      end
      if (req_pop) model_push(req_data, req_addr, req_size);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(output int pcyc);
    bit got;
    got = 0;
    pcyc = -1;
    req_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_pop) begin
        got = 1;
        pcyc = cyc;
        break;
      end
    end
    if (!got) check("pop_timeout", 0, 1);
    tick;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(output int dcyc, output int nwen, output int nerr);
    dcyc = -1;
    nwen = 0;
    nerr = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (mem_wen) nwen++;
      if (err) nerr++;
      if (done_valid) begin
        dcyc = cyc;
        break;
      end
    end
    if (dcyc < 0) check("done_timeout", 0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int p, d, n, e, pops, dn;
    bit popped;
    logic [65:0] w2;
    logic [36:0] a2;
    logic [7:0] m;

    // Reset state, with a request offered while reset is held.
    req_valid = 1'b1;
    repeat (3) tick;
    check("rst_pop", req_pop, 0);
    check("rst_wen", mem_wen, 0);
    check("rst_maddr", mem_addr, 0);
    check("rst_done", done_valid, 0);
    check("rst_daddr", done_addr, 0);
    check("rst_err", err, 0);
    req_valid = 1'b0;
    rst = 1'b1;
    tick;

    // Full-mask line.
    tick;
    new_req(8'hFF, 0);
    req_addr = 37'h1_2345_6780;
    send(p);
    wait_done(d, n, e);
    check("t1_lat", d - p, 10);
    check("t1_nwen", n, 8);

    // Sparse and empty masks.
    tick;
    new_req(8'hA1, 0);
    send(p);
    wait_done(d, n, e);
    check("t2_lat", d - p, 5);
    check("t2_nwen", n, 3);
    tick;
    new_req(8'h00, 0);
    send(p);
    wait_done(d, n, e);
    check("t2z_lat", d - p, 2);
    check("t2z_nwen", n, 0);

    // Three-cycle stall on word 2.
    tick;
    new_req(8'hFF, 0);
    w2 = req_data[132 +: 66];
    a2 = req_addr;
    send(p);
    while (cyc < p + 4) tick;
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_stall_wen", mem_wen, 1);
      check("t3_stall_addr", mem_addr, {a2, 3'd2});
      check("t3_stall_data", mem_wdata, w2);
      tick;
    end
    mem_ready = 1'b1;
    wait_done(d, n, e);
    check("t3_lat", d - p, 13);

    // Backpressure fills exactly DEPTH entries.
    tick;
    mem_ready = 1'b0;
    pops = 0;
    new_req(8'($urandom) | 8'h01, 0);
    req_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      popped = req_pop;
      if (popped) pops++;
      tick;
      if (popped) new_req(8'($urandom) | 8'h01, 0);
    end
    check("t4_pops", pops, DEP);
    @(negedge clk);
    check("t4_pop_low", req_pop, 0);

    // Random traffic with random memory backpressure.
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      popped = req_pop;
      tick;
      mem_ready = ($urandom_range(0, 3) != 0);
      if (!req_valid || popped) begin
        req_valid = ($urandom_range(0, 2) != 0);
        if (req_valid) begin
          m = 8'($urandom);
          if ($urandom_range(0, 5) == 0) m = 8'h00;
          if ($urandom_range(0, 5) == 0) m = 8'hFF;
          new_req(m, 1);
        end
      end
    end
    tick;
    req_valid = 1'b0;
    mem_ready = 1'b1;
    for (int k = 0; k < 500; k++) begin
      if (exp_done.size() == 0) break;
      tick;
    end
    repeat (3) tick;
    check("drain_wr", exp_wr.size(), 0);
    check("drain_done", exp_done.size(), 0);

    // Reset in the middle of word 4.
    new_req(8'hFF, 0);
    send(p);
    while (cyc < p + 6) tick;
    check("t5_pre_idx", mem_addr[2:0], 4);
    check("t5_pre_wen", mem_wen, 1);
    #2;
    rst = 1'b0;
    #1;
    check("t5_wen", mem_wen, 0);
    check("t5_maddr", mem_addr, 0);
    check("t5_wdata", mem_wdata, 0);
    check("t5_done", done_valid, 0);
    tick;
    tick;
    rst = 1'b1;
    dn = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done_valid) dn++;
    end
    check("t5_no_done", dn, 0);
    tick;
    new_req(8'hFF, 0);
    send(p);
    wait_done(d, n, e);
    check("t5_lat", d - p, 10);

`ifdef TILE_DRAIN_ECC_EN
    // Corrupt check bit on word 3.
    tick;
    new_req(8'hFF, 0);
    req_data[3*66 + 64] = ~req_data[3*66 + 64];
    send(p);
    wait_done(d, n, e);
    check("t6_nwen", n, 7);
    check("t6_nerr", e, 1);
    check("t6_lat", d - p, 10);
`endif

    repeat (3) tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
